// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared constants, FSM states and result-select codes for the convolution sequencer.
package conv_sched_pkg;
    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int TAPS   = 9;

    localparam logic [3:0] PH_BIAS  = 4'd9;
    localparam logic [3:0] PH_ROUND = 4'd10;
    localparam logic [3:0] CNT_OFF  = 4'd15;

    localparam logic [1:0] CSEL_NONE = 2'd0;
    localparam logic [1:0] CSEL_K0   = 2'd1;
    localparam logic [1:0] CSEL_K1   = 2'd2;

    typedef enum logic [2:0] {IDLE, PREF, RUN, DRAIN, WRITE, FIN} state_e;
endpackage

// File: rtl/conv_sched_tap.sv
// conv_tap_addr: maps window tap k of pixel (row, col) to an image address and a zero-padding flag.
module conv_tap_addr
    import conv_sched_pkg::*;
#(
    parameter int IMG_COLS = IMG_W,
    parameter int IMG_ROWS = IMG_H,
    localparam int CW = $clog2(IMG_COLS),
    localparam int RW = $clog2(IMG_ROWS)
)(
    input  logic [RW-1:0]     row,
    input  logic [CW-1:0]     col,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] addr,
    output logic              pad
);
    logic [3:0] dy, dx;
    logic pad_r, pad_c;

    always_comb begin
        dy = k / 4'd3;
        dx = k % 4'd3;
        // offsets 0 and 2 step one row/col outside the centre; padding is decided before any subtraction
        pad_r = (dy == 4'd0 && row == '0) || (dy == 4'd2 && int'(row) == IMG_ROWS - 1);
        pad_c = (dx == 4'd0 && col == '0) || (dx == 4'd2 && int'(col) == IMG_COLS - 1);
        pad = pad_r || pad_c;
        addr = pad ? '0 : (ADDR_W'(row) + ADDR_W'(dy) - ADDR_W'(1)) * ADDR_W'(IMG_COLS)
                        + ADDR_W'(col) + ADDR_W'(dx) - ADDR_W'(1);
    end
endmodule

// File: rtl/conv_sched.sv
// conv_sched: raster-order sequencer driving a shared 3x3 MAC datapath, two kernels per pixel.
// Define CONV_DONE_CHECK_EN to add a sticky err output flagging a missing mac_done in DRAIN.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int IMG_COLS = IMG_W,
    parameter int IMG_ROWS = IMG_H
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [DATA_W-1:0] idata,
    output logic [DATA_W-1:0] mac_fm,
    output logic [3:0]        mac_counter,
    output logic              mac_sel_kernal,
    output logic              mac_clk_en,
    input  logic [DATA_W-1:0] mac_pixel,
    input  logic              mac_done,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [1:0]        csel
`ifdef CONV_DONE_CHECK_EN
    ,
    output logic              err
`endif
);
    localparam int CW = $clog2(IMG_COLS);
    localparam int RW = $clog2(IMG_ROWS);

    state_e state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic kern_q, kern_d;
    logic [3:0] cnt_q, cnt_d;
    logic pad_q, pad_d;
    logic [3:0] tap_k;
    logic [ADDR_W-1:0] tap_addr;
    logic tap_pad, col_end, last_px, wr;

    conv_tap_addr #(.IMG_COLS(IMG_COLS), .IMG_ROWS(IMG_ROWS)) u_tap (
        .row(row_q), .col(col_q), .k(tap_k), .addr(tap_addr), .pad(tap_pad)
    );

    // the address for tap k+1 goes out while tap k is consumed, matching the 1-cycle read latency
    assign tap_k   = state_q == RUN ? cnt_q + 4'd1 : 4'd0;
    assign col_end = int'(col_q) == IMG_COLS - 1;
    assign last_px = col_end && int'(row_q) == IMG_ROWS - 1;
    assign wr      = state_q == WRITE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            kern_q  <= 1'b0;
            cnt_q   <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            kern_q  <= kern_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        kern_d  = kern_q;
        cnt_d   = '0;
        pad_d   = tap_pad;
        case (state_q)
            IDLE: if (ready) begin
                state_d = PREF;
                row_d   = '0;
                col_d   = '0;
                kern_d  = 1'b0;
            end
            PREF: state_d = RUN;
            RUN: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == PH_ROUND ? DRAIN : RUN;
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                kern_d  = !kern_q;
                col_d   = kern_q ? (col_end ? '0 : col_q + CW'(1)) : col_q;
                row_d   = (kern_q && col_end) ? row_q + RW'(1) : row_q;
                state_d = (kern_q && last_px) ? FIN : PREF;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy           = state_q inside {PREF, RUN, DRAIN, WRITE};
        done           = state_q == FIN;
        iaddr          = (state_q == PREF || (state_q == RUN && cnt_q < 4'(TAPS - 1))) ? tap_addr : '0;
        mac_fm         = (state_q == RUN && cnt_q < PH_BIAS && !pad_q) ? idata : '0;
        mac_counter    = state_q == RUN ? cnt_q : CNT_OFF;
        mac_clk_en     = state_q == RUN;
        mac_sel_kernal = kern_q;
        cwr            = wr;
        caddr_wr       = wr ? ADDR_W'(row_q) * ADDR_W'(IMG_COLS) + ADDR_W'(col_q) : '0;
        cdata_wr       = wr ? mac_pixel : '0;
        csel           = wr ? (kern_q ? CSEL_K1 : CSEL_K0) : CSEL_NONE;
    end

`ifdef CONV_DONE_CHECK_EN
    logic err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    always_comb begin
        err_d = (state_q == IDLE && ready) ? 1'b0 : err_q || (state_q == DRAIN && !mac_done);
    end

    assign err = err_q;
`else
    logic unused_mac_done;
    assign unused_mac_done = mac_done;
`endif
endmodule
